imem_loader: RTL and testbench

- Writer side of the instruction memory: receives a boot image as a byte stream and writes it into the instruction store as 32-bit little-endian words.
- Addresses are CPU-visible, starting at the reset-vector base BASE_ADDR.
- Holds the core in reset until the image is fully written.
- Sits between the boot byte source (UART/JTAG bridge) and the instruction memory write port.

---
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Boot image byte stream -> 32-bit little-endian instruction writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int          MEM_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        WE,
  output logic [31:0] WA,
  output logic [31:0] WD,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  localparam int CNT_W = $clog2(MEM_BYTES) + 1;
  localparam int OFS_W = $clog2(MEM_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [31:0]      MAX_LEN   = 32'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [31:0]      len_q, len_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]      acc_q, acc_d;
  logic             we_q, we_d;
  logic [31:0]      wa_q, wa_d;
  logic [31:0]      wd_q, wd_d;

  logic             xfer;
  logic [1:0]       lane;
  logic [31:0]      merged;
  logic [31:0]      len_new;
  logic             last_byte;
  logic [OFS_W-1:0] word_ofs;

  assign byte_ready = (state_q == S_HDR) || (state_q == S_DATA);
  assign xfer       = byte_valid && byte_ready;
  assign lane       = byte_cnt_q[1:0];
  assign merged     = acc_q | ({24'd0, byte_data} << {lane, 3'b000});
  // Header bytes enter at the top and shift down, so the first lands in [7:0].
  assign len_new    = {byte_data, len_q[31:8]};
  assign last_byte  = ((32'(byte_cnt_q) + 32'd1) == len_q);
  assign word_ofs   = {byte_cnt_q[OFS_W-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    acc_d      = acc_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          hdr_cnt_d  = 2'd0;
          len_d      = 32'd0;
          byte_cnt_d = '0;
          acc_d      = 32'd0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          len_d     = len_new;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            byte_cnt_d = '0;
            acc_d      = 32'd0;
            if (len_new == 32'd0)       state_d = S_DONE;
            else if (len_new > MAX_LEN) state_d = S_ERR;
            else                        state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + CNT_ONE;
          if ((lane == 2'd3) || last_byte) begin
            we_d  = 1'b1;
            wa_d  = BASE_ADDR + 32'(word_ofs);
            wd_d  = merged;
            acc_d = 32'd0;
          end else begin
            acc_d = merged;
          end
          if (last_byte) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hdr_cnt_q  <= 2'd0;
      len_q      <= 32'd0;
      byte_cnt_q <= '0;
      acc_q      <= 32'd0;
      we_q       <= 1'b0;
      wa_q       <= 32'd0;
      wd_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      acc_q      <= acc_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
    end
  end

  assign WE       = we_q;
  assign WA       = wa_q;
  assign WD       = wd_q;
  assign busy     = (state_q == S_HDR) || (state_q == S_DATA);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign cpu_hold = (state_q != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Scoreboard bench for imem_loader: expected writes queued, monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        WE;
  logic [31:0] WA;
  logic [31:0] WD;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .WE(WE), .WA(WA), .WD(WD),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Write monitor: every WE pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && WE) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_we: got WA=%08h WD=%08h expected no write", WA, WD);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("WA", WA, e[63:32]);
        chk("WD", WD, e[31:0]);
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  // Present one byte until it is accepted; optional idle gap and concurrent start.
  task automatic send_byte(input logic [7:0] b, input int gap, input logic with_start);
    int t;
    byte_valid = 1'b0;
    if (gap > 0) cycles(gap);
    byte_valid = 1'b1;
    byte_data  = b;
    start      = with_start;
    t = 0;
    while (!byte_ready && t < 200) begin
      cycles(1);
      start = 1'b0;
      t++;
    end
    if (!byte_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout: got byte_ready=0 expected 1");
    end
    cycles(1);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[], input logic rnd, input int start_at);
    foreach (s[i])
      send_byte(s[i], rnd ? int'($urandom_range(0, 3)) : 0, (i == start_at));
  endtask

  task automatic settle_and_check_done(input string tag, input int we_before, input int n_we);
    cycles(3);
    chk({tag, "_we_count"}, 32'(we_cnt - we_before), 32'(n_we));
    chk({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, WE}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_wa"}, WA, 32'd0);
    chk({tag, "_wd"}, WD, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s1[] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                         8'h13, 8'h01, 8'h30, 8'h00};
    logic [7:0] s2[] = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00, 8'h33};
    logic [7:0] s3[] = '{8'h01, 8'h10, 8'h00, 8'h00};
    logic [7:0] s4[] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h00, 8'h00, 8'hFF};
    logic [7:0] s0[] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] s5[] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                         8'h55, 8'h66};
    logic [7:0] s6[] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] hmax[] = '{8'h00, 8'h10, 8'h00, 8'h00};
    int w0;

    cycles(3);
    rst = 1'b0;
    cycles(1);
    check_reset_outputs("reset");

    // Bytes offered in IDLE are not taken.
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    cycles(3);
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    byte_valid = 1'b0;

    // Two full words, back-to-back bytes.
    pulse_start();
    chk("hdr_busy", {31'd0, busy}, 32'd1);
    chk("hdr_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    push(32'hBFC00000, 32'h00500093);
    push(32'hBFC00004, 32'h00300113);
    w0 = we_cnt;
    send_seq(s1, 1'b0, -1);
    settle_and_check_done("s1", w0, 2);

    // Partial final word, zero-filled.
    pulse_start();
    chk("restart_done_clr", {31'd0, done}, 32'd0);
    chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
    push(32'hBFC00000, 32'h002081B3);
    push(32'hBFC00004, 32'h00000033);
    w0 = we_cnt;
    send_seq(s2, 1'b0, -1);
    settle_and_check_done("s2", w0, 2);

    // Oversize image rejected, then recovered by a new session.
    pulse_start();
    w0 = we_cnt;
    send_seq(s3, 1'b0, -1);
    cycles(3);
    chk("err_flag", {31'd0, err}, 32'd1);
    chk("err_ready", {31'd0, byte_ready}, 32'd0);
    chk("err_hold", {31'd0, cpu_hold}, 32'd1);
    chk("err_no_we", 32'(we_cnt - w0), 32'd0);
    pulse_start();
    chk("err_clr", {31'd0, err}, 32'd0);
    push(32'hBFC00000, 32'hFF0000EF);
    w0 = we_cnt;
    send_seq(s4, 1'b0, -1);
    settle_and_check_done("s4", w0, 1);

    // LEN==0 completes with no writes.
    pulse_start();
    w0 = we_cnt;
    send_seq(s0, 1'b0, -1);
    settle_and_check_done("len0", w0, 0);

    // Gapped stream with a stray start mid-payload.
    pulse_start();
    push(32'hBFC00000, 32'h002081B3);
    push(32'hBFC00004, 32'h00000033);
    w0 = we_cnt;
    send_seq(s2, 1'b1, 6);
    settle_and_check_done("gap", w0, 2);

    // LEN == MEM_BYTES is legal; payload byte k = k[7:0].
    pulse_start();
    for (int j = 0; j < 1024; j++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(4 * j);     b1 = 8'(4 * j + 1);
      b2 = 8'(4 * j + 2); b3 = 8'(4 * j + 3);
      push(32'hBFC00000 + 32'(4 * j), {b3, b2, b1, b0});
    end
    w0 = we_cnt;
    send_seq(hmax, 1'b0, -1);
    for (int k = 0; k < 4096; k++) send_byte(8'(k), 0, 1'b0);
    settle_and_check_done("max", w0, 1024);

    // Reset mid-payload: only the first completed word is written.
    pulse_start();
    push(32'hBFC00000, 32'h44332211);
    w0 = we_cnt;
    send_seq(s5, 1'b0, -1);
    rst = 1'b1;
    cycles(1);
    check_reset_outputs("midrst");
    cycles(2);
    rst = 1'b0;
    cycles(4);
    chk("midrst_we_count", 32'(we_cnt - w0), 32'd1);
    chk("midrst_sb_drained", 32'(exp_q.size()), 32'd0);
    pulse_start();
    push(32'hBFC00000, 32'h04030201);
    w0 = we_cnt;
    send_seq(s6, 1'b0, -1);
    settle_and_check_done("fresh", w0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
